// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage types: access-size codes, byte-lane masks, load extension.
package mem_stage_pkg;

  localparam int INST_SZ = 32;
  localparam int BHW_SZ  = 3;

  localparam logic [BHW_SZ-1:0] BHW_BYTE_S = 3'b000;
  localparam logic [BHW_SZ-1:0] BHW_HALF_S = 3'b001;
  localparam logic [BHW_SZ-1:0] BHW_WORD   = 3'b010;
  localparam logic [BHW_SZ-1:0] BHW_BYTE_U = 3'b100;
  localparam logic [BHW_SZ-1:0] BHW_HALF_U = 3'b101;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_sz_e;

  typedef struct packed {
    logic              valid;
    logic [BHW_SZ-1:0] bhw;
    logic [1:0]        lane;
  } ld_ctl_t;

  // Unlisted codes fall back to a full word access.
  function automatic acc_sz_e bhw_size(
    input logic [BHW_SZ-1:0] bhw
  );
    case (bhw)
      BHW_BYTE_S, BHW_BYTE_U: return SZ_BYTE;
      BHW_HALF_S, BHW_HALF_U: return SZ_HALF;
      default:                return SZ_WORD;
    endcase
  endfunction

  function automatic logic [INST_SZ-1:0] load_ext(
    input logic [INST_SZ-1:0] w,
    input logic [BHW_SZ-1:0]  bhw,
    input logic [1:0]         lane
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic        sgn;
    b   = w[{lane, 3'b000} +: 8];
    h   = lane[1] ? w[31:16] : w[15:0];
    sgn = ~bhw[2];
    case (bhw_size(bhw))
      SZ_BYTE: return {{(INST_SZ-8){sgn & b[7]}}, b};
      SZ_HALF: return {{(INST_SZ-16){sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word RAM with byte write enables, one synchronous read port and a
// synchronous debug read port; reads return the pre-write word.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rd_en,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [3:0]         i_be,
  input  logic [INST_SZ-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_dbg_addr,
  output logic [INST_SZ-1:0] o_rdata,
  output logic [INST_SZ-1:0] o_dbg_data
);

  logic [INST_SZ-1:0] mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    for (int l = 0; l < 4; l++) begin
      if (i_be[l]) mem[i_addr][l*8 +: 8] <= i_wdata[l*8 +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rdata    <= '0;
      o_dbg_data <= '0;
    end else begin
      if (i_rd_en) o_rdata <= mem[i_addr];
      o_dbg_data <= mem[i_dbg_addr];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte/half/word load-store and MEM/WB registers.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic [INST_SZ-1:0] i_alu_result_E,
  input  logic [INST_SZ-1:0] i_operand_b_E,
  input  logic [4:0]         i_instr_rd_E,
  input  logic               i_mem_read_MC,
  input  logic               i_mem_write_MC,
  input  logic [BHW_SZ-1:0]  i_bhw_MC,
  input  logic               i_reg_write_MC,
  input  logic               i_mem_to_reg_MC,
  input  logic [ADDR_W-1:0]  i_dbg_addr,
  output logic [INST_SZ-1:0] o_read_data_M,
  output logic [INST_SZ-1:0] o_alu_result_M,
  output logic [4:0]         o_instr_rd_M,
  output logic               o_reg_write_M,
  output logic               o_mem_to_reg_M,
  output logic [INST_SZ-1:0] o_dbg_data,
  output logic               o_misalign_M
);

  logic [ADDR_W-1:0]  word_idx;
  logic [1:0]         lane;
  acc_sz_e            sz;
  logic               misalign;
  logic               do_write;
  logic [3:0]         be;
  logic [INST_SZ-1:0] wdata;
  logic [INST_SZ-1:0] rdata;
  ld_ctl_t            ld_q;

  assign word_idx = i_alu_result_E[ADDR_W+1:2];
  assign lane     = i_alu_result_E[1:0];
  assign sz       = bhw_size(i_bhw_MC);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (i_mem_read_MC | i_mem_write_MC)
                  & (((sz == SZ_HALF) & lane[0])
                  | ((sz == SZ_WORD) & (|lane)));
`else
  assign misalign = 1'b0;
`endif

  assign do_write = i_enable & i_mem_write_MC & ~i_flush
                  & ~misalign & ~i_reset;

  always_comb begin
    be    = BE_WORD;
    wdata = i_operand_b_E;
    unique case (1'b1)
      sz == SZ_BYTE: begin
        be    = BE_BYTE << lane;
        wdata = {4{i_operand_b_E[7:0]}};
      end
      sz == SZ_HALF: begin
        be    = lane[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata = {2{i_operand_b_E[15:0]}};
      end
      default: begin
        be    = BE_WORD;
        wdata = i_operand_b_E;
      end
    endcase
    if (!do_write) be = '0;
  end

  data_memory #(
    .ADDR_W(ADDR_W)
  ) u_dmem (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_rd_en   (i_enable),
    .i_addr    (word_idx),
    .i_be      (be),
    .i_wdata   (wdata),
    .i_dbg_addr(i_dbg_addr),
    .o_rdata   (rdata),
    .o_dbg_data(o_dbg_data)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_alu_result_M <= '0;
      o_instr_rd_M   <= '0;
      o_reg_write_M  <= 1'b0;
      o_mem_to_reg_M <= 1'b0;
      o_misalign_M   <= 1'b0;
      ld_q           <= '0;
    end else if (i_enable) begin
      o_alu_result_M <= i_alu_result_E;
      if (i_flush) begin
        o_instr_rd_M   <= '0;
        o_reg_write_M  <= 1'b0;
        o_mem_to_reg_M <= 1'b0;
        o_misalign_M   <= 1'b0;
        ld_q           <= '0;
      end else begin
        o_instr_rd_M   <= i_instr_rd_E;
        o_reg_write_M  <= i_reg_write_MC;
        o_mem_to_reg_M <= i_mem_to_reg_MC;
        o_misalign_M   <= misalign;
        ld_q.valid     <= i_mem_read_MC & ~misalign;
        ld_q.bhw       <= i_bhw_MC;
        ld_q.lane      <= lane;
      end
    end
  end

  // Raw word is registered in the RAM; lane select/extension uses the
  // registered control so the output holds and clears with the stage.
  assign o_read_data_M = ld_q.valid ? load_ext(rdata, ld_q.bhw, ld_q.lane)
                                    : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage against a byte-array model.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        en;
  logic        fl;
  logic [31:0] alu;
  logic [31:0] opb;
  logic [4:0]  rd;
  logic        mr;
  logic        mw;
  logic [2:0]  bhw;
  logic        rw;
  logic        m2r;
  logic [7:0]  dbg;

  logic [31:0] read_data;
  logic [31:0] alu_m;
  logic [4:0]  rd_m;
  logic        rw_m;
  logic        m2r_m;
  logic [31:0] dbg_data;
  logic        mis_m;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mb [1024];
  logic [31:0] e_rdata, e_alu, e_dbg;
  logic [4:0]  e_rd;
  logic        e_rw, e_m2r, e_mis;
  logic [31:0] held;

  mem_stage #(.ADDR_W(8)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_flush        (fl),
    .i_alu_result_E (alu),
    .i_operand_b_E  (opb),
    .i_instr_rd_E   (rd),
    .i_mem_read_MC  (mr),
    .i_mem_write_MC (mw),
    .i_bhw_MC       (bhw),
    .i_reg_write_MC (rw),
    .i_mem_to_reg_MC(m2r),
    .i_dbg_addr     (dbg),
    .o_read_data_M  (read_data),
    .o_alu_result_M (alu_m),
    .o_instr_rd_M   (rd_m),
    .o_reg_write_M  (rw_m),
    .o_mem_to_reg_M (m2r_m),
    .o_dbg_data     (dbg_data),
    .o_misalign_M   (mis_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] s);
    if (s == 3'b000 || s == 3'b100) return 1;
    if (s == 3'b001 || s == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int base_of(input logic [31:0] a, input int n);
    int ba;
    ba = int'(a[9:0]);
    return ba - (ba % n);
  endfunction

  function automatic logic [31:0] mword(input int wi);
    return {mb[wi*4+3], mb[wi*4+2], mb[wi*4+1], mb[wi*4]};
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a,
                                        input logic [2:0] s);
    int n, b;
    longint v;
    n = nbytes(s);
    b = base_of(a, n);
    v = 0;
    for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(mb[b + k]);
    if (n < 4 && !s[2] && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic is_mis(input logic [31:0] a, input logic [2:0] s,
                                  input logic r, input logic w);
`ifdef MEM_ALIGN_CHECK_EN
    return (r || w) && (int'(a[1:0]) % nbytes(s) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rdata"}, read_data, e_rdata);
    chk({tag, ".alu"}, alu_m, e_alu);
    chk({tag, ".rd"}, {27'd0, rd_m}, {27'd0, e_rd});
    chk({tag, ".rw"}, {31'd0, rw_m}, {31'd0, e_rw});
    chk({tag, ".m2r"}, {31'd0, m2r_m}, {31'd0, e_m2r});
    chk({tag, ".dbg"}, dbg_data, e_dbg);
    chk({tag, ".mis"}, {31'd0, mis_m}, {31'd0, e_mis});
  endtask

  task automatic tick(input string tag);
    logic m;
    int n, b;
    e_dbg = mword(int'(dbg));
    if (en) begin
      m = is_mis(alu, bhw, mr, mw);
      e_alu = alu;
      if (fl) begin
        e_rd = 0; e_rw = 0; e_m2r = 0; e_rdata = 0; e_mis = 0;
      end else begin
        e_rd = rd; e_rw = rw; e_m2r = m2r; e_mis = m;
        e_rdata = (mr && !m) ? mload(alu, bhw) : 32'd0;
        if (mw && !m) begin
          n = nbytes(bhw);
          b = base_of(alu, n);
          for (int k = 0; k < n; k++) mb[b + k] = opb[k*8 +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input logic e, input logic f,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic r, input logic w, input logic [2:0] s,
                     input logic [4:0] d, input logic regw,
                     input logic m2);
    en = e; fl = f; alu = a; opb = b; mr = r; mw = w;
    bhw = s; rd = d; rw = regw; m2r = m2;
    tick(tag);
  endtask

  initial begin
    rst = 1'b1; en = 0; fl = 0; alu = 0; opb = 0; rd = 0;
    mr = 0; mw = 0; bhw = 0; rw = 0; m2r = 0; dbg = 0;
    for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
    e_rdata = 0; e_alu = 0; e_rd = 0; e_rw = 0; e_m2r = 0;
    e_dbg = 0; e_mis = 0;
    #1;
    check_all("reset");
    @(posedge clk); @(posedge clk); #1;
    check_all("reset_hold");
    rst = 1'b0;

    for (int i = 0; i < 256; i++)
      run("clear", 1, 0, i * 4, 0, 0, 1, 3'b010, 0, 0, 0);

    run("sw_10", 1, 0, 32'h10, 32'hDEADBEEF, 0, 1, 3'b010, 0, 0, 0);
    dbg = 8'd4;
    run("lw_10", 1, 0, 32'h10, 0, 1, 0, 3'b010, 3, 1, 1);
    chk("lw_10.const", read_data, 32'hDEADBEEF);
    chk("dbg_4.const", dbg_data, 32'hDEADBEEF);

    run("sw_20", 1, 0, 32'h20, 32'h80F17F22, 0, 1, 3'b010, 0, 0, 0);
    run("lb_23", 1, 0, 32'h23, 0, 1, 0, 3'b000, 4, 1, 1);
    chk("lb_23.const", read_data, 32'hFFFFFF80);
    run("lbu_23", 1, 0, 32'h23, 0, 1, 0, 3'b100, 4, 1, 1);
    chk("lbu_23.const", read_data, 32'h00000080);
    run("lh_22", 1, 0, 32'h22, 0, 1, 0, 3'b001, 4, 1, 1);
    chk("lh_22.const", read_data, 32'hFFFF80F1);
    run("lhu_20", 1, 0, 32'h20, 0, 1, 0, 3'b101, 4, 1, 1);
    chk("lhu_20.const", read_data, 32'h00007F22);
    run("lw_bad", 1, 0, 32'h20, 0, 1, 0, 3'b111, 4, 1, 1);
    chk("lw_bad.const", read_data, 32'h80F17F22);

    run("sw_30", 1, 0, 32'h30, 32'h11223344, 0, 1, 3'b010, 0, 0, 0);
    run("sb_31", 1, 0, 32'h31, 32'h000000AA, 0, 1, 3'b000, 0, 0, 0);
    run("lw_30a", 1, 0, 32'h30, 0, 1, 0, 3'b010, 7, 1, 1);
    chk("sb_merge.const", read_data, 32'h1122AA44);
    run("sh_32", 1, 0, 32'h32, 32'h0000BEEF, 0, 1, 3'b001, 0, 0, 0);
    run("lw_30b", 1, 0, 32'h30, 0, 1, 0, 3'b010, 7, 1, 1);
    chk("sh_merge.const", read_data, 32'hBEEFAA44);

    run("pass", 1, 0, 32'h12345678, 0, 0, 0, 3'b010, 9, 1, 0);
    chk("pass.alu", alu_m, 32'h12345678);
    chk("pass.rd", {27'd0, rd_m}, 32'd9);
    chk("pass.rdata", read_data, 32'd0);

    run("wrap_sw", 1, 0, 32'hFFFF_F410, 32'hCAFEF00D, 0, 1, 3'b010, 0, 0, 0);
    run("wrap_lw", 1, 0, 32'h10, 0, 1, 0, 3'b010, 1, 1, 1);
    run("restore", 1, 0, 32'h10, 32'hDEADBEEF, 0, 1, 3'b010, 0, 0, 0);

    run("flush_sw", 1, 1, 32'h10, 32'h55555555, 0, 1, 3'b010, 6, 1, 1);
    chk("flush.rw", {31'd0, rw_m}, 32'd0);
    run("flush_lw", 1, 0, 32'h10, 0, 1, 0, 3'b010, 2, 1, 1);
    chk("flush.mem", read_data, 32'hDEADBEEF);

    held = alu_m;
    for (int i = 0; i < 3; i++)
      run("stall", 0, i == 1, 32'h44, 32'h99999999, 1, 1, 3'b010,
          11, 0, 0);
    chk("stall.alu", alu_m, held);
    run("stall_lw", 1, 0, 32'h44, 0, 1, 0, 3'b010, 2, 1, 1);

    run("rbw", 1, 0, 32'h20, 32'h01020304, 1, 1, 3'b010, 5, 1, 1);
    chk("rbw.const", read_data, 32'h80F17F22);
    run("rbw_after", 1, 0, 32'h20, 0, 1, 0, 3'b010, 5, 1, 1);

    run("pre_rst", 1, 0, 32'h10, 0, 1, 0, 3'b010, 5, 1, 1);
    en = 1; fl = 0; alu = 32'h10; opb = 32'h77777777;
    mr = 0; mw = 1; bhw = 3'b010; rd = 8; rw = 1; m2r = 0;
    rst = 1'b1;
    #1;
    e_rdata = 0; e_alu = 0; e_rd = 0; e_rw = 0; e_m2r = 0;
    e_dbg = 0; e_mis = 0;
    check_all("rst_async");
    @(posedge clk); #1;
    check_all("rst_edge");
    rst = 1'b0;
    run("rst_lw", 1, 0, 32'h10, 0, 1, 0, 3'b010, 5, 1, 1);
    chk("rst_store.const", read_data, 32'hDEADBEEF);

    run("sw_41", 1, 0, 32'h41, 32'hA5A5A5A5, 0, 1, 3'b010, 0, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("sw_41.mis", {31'd0, mis_m}, 32'd1);
`else
    chk("sw_41.mis", {31'd0, mis_m}, 32'd0);
`endif
    run("lw_40", 1, 0, 32'h40, 0, 1, 0, 3'b010, 1, 1, 1);
`ifdef MEM_ALIGN_CHECK_EN
    chk("sw_41.mem", read_data, 32'h00000000);
`else
    chk("sw_41.mem", read_data, 32'hA5A5A5A5);
`endif

    for (int i = 0; i < 600; i++) begin
      dbg = 8'($urandom_range(0, 31));
      run("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
          ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 127)),
          $urandom, 1'($urandom), 1'($urandom),
          3'($urandom_range(0, 7)), 5'($urandom), 1'($urandom),
          1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM pipeline stage. Consumes EX-stage outputs: ALU result as byte address, operand B as store data, and destination register. Performs byte/half/word loads and stores against an internal data memory, then registers results into the MEM/WB boundary for the write-back stage and the forwarding unit.

Parameters:
INST_SZ, 32, datapath and word width in bits
ADDR_W, 8, word-address width; memory holds 2^ADDR_W words
BHW_SZ, 3, width of the access-size/sign control field

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  pipeline advance; low holds all state
i_flush  in  1  insert a bubble at the MEM/WB boundary
i_alu_result_E  in  INST_SZ  byte address, or ALU result passed through
i_operand_b_E  in  INST_SZ  store data (rt)
i_instr_rd_E  in  5  destination register
i_mem_read_MC  in  1  load
i_mem_write_MC  in  1  store
i_bhw_MC  in  BHW_SZ  access size/sign: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned
i_reg_write_MC  in  1  WB control, passed through
i_mem_to_reg_MC  in  1  WB control, passed through
i_dbg_addr  in  ADDR_W  debug word address
o_read_data_M  out  INST_SZ  extended load data (registered)
o_alu_result_M  out  INST_SZ  registered i_alu_result_E
o_instr_rd_M  out  5  registered rd
o_reg_write_M  out  1  registered control
o_mem_to_reg_M  out  1  registered control
o_dbg_data  out  INST_SZ  registered memory word at i_dbg_addr
o_misalign_M  out  1  registered misalignment flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high): every output clears to 0 immediately. A store in the reset cycle is discarded. Memory contents are not reset; they initialise to 0 at simulation start.
- Address decode: word index = i_alu_result_E[ADDR_W+1:2]; byte lane = [1:0]. Little-endian lanes: lane 0 is bits 7:0. Upper address bits are ignored, so addresses wrap modulo memory size.
- Store (i_enable & i_mem_write_MC & !i_flush, rising edge):
  - byte: writes lane addr[1:0] with operand_b[7:0]
  - half: writes lanes {addr[1],0} and {addr[1],1} with operand_b[15:0]
  - word: writes all 4 lanes
  - Unwritten lanes keep their values.
- Load: synchronous read; latency 1.
  - At the edge, the selected lane(s) are extracted and sign- or zero-extended per i_bhw_MC, then registered into o_read_data_M.
  - When i_mem_read_MC is 0, o_read_data_M loads 0.
- Pass-through registers: alu_result, rd, reg_write and mem_to_reg register on each enabled edge.
- i_flush with i_enable: at the edge, o_reg_write_M, o_mem_to_reg_M, o_read_data_M, o_instr_rd_M and o_misalign_M load 0, and the memory write is suppressed.
- i_enable low: all registers hold and no memory write occurs. Flush is ignored while enable is low.
- Read and write asserted together: write takes effect; the registered read returns the pre-write word (read-before-write).
- Debug port: o_dbg_data = mem[i_dbg_addr], registered every clock independent of i_enable, with read-before-write ordering.
- Invalid i_bhw_MC codes (011, 110, 111) are treated as word.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, asserts o_misalign_M for one registered cycle.
  - The store is suppressed and o_read_data_M loads 0.
  - Pass-through outputs register normally.
- Undefined: low address bits below access size are ignored (half uses addr[1], word ignores [1:0]); o_misalign_M is tied 0.

Decomposition:
- Shared package holds:
  - INST_SZ
  - the BHW_* encoding constants (BHW_BYTE_S, BHW_HALF_S, BHW_WORD, BHW_BYTE_U, BHW_HALF_U)
  - the lane-select helper constants
- Sub-module data_memory: 2^ADDR_W x INST_SZ RAM with a 4-bit byte write-enable, one synchronous read port, and one synchronous debug read port.
- Extraction, extension and pipeline registers stay in mem_stage.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x10, then load word at 0x10 with mem_to_reg=1 -> o_read_data_M=0xDEADBEEF one edge later; o_dbg_data at word 4 = 0xDEADBEEF.
- Byte/half extension: preload 0x80F17F22 at 0x20.
  - lb 0x23 -> 0xFFFFFF80
  - lbu 0x23 -> 0x00000080
  - lh 0x22 -> 0xFFFF80F1
  - lhu 0x20 -> 0x00007F22
- Partial store merge: word 0x11223344 at 0x30, then sb 0xAA at 0x31 -> word reads 0x1122AA44; sh 0xBEEF at 0x32 -> 0xBEEFAA44.
- Pass-through with no memory op: alu_result 0x12345678, rd=9, reg_write=1 -> next edge o_alu_result_M=0x12345678, o_instr_rd_M=9, o_read_data_M=0.
- Flush and stall:
  - Store with flush=1 -> memory unchanged, o_reg_write_M=0.
  - enable=0 for 3 cycles -> all outputs hold.
  - Assert reset mid-store -> outputs are 0 asynchronously and the word is unchanged.
- With MEM_ALIGN_CHECK_EN: sw at 0x41 -> o_misalign_M=1 and memory unchanged; without it, the same store writes word 0x40.
